vx_tcu_drl_norm_pack: RTL and testbench

- Back end of the TCU DRL floating-point dot-product datapath; the inverse of the exponent-bias stage.
- Accepts the signed fixed-point window accumulator and its biased window exponent.
- Normalizes the magnitude, removes the window offset, rounds to nearest-even and packs an IEEE FP32 result.
- 3-stage elastic pipeline with valid/ready handshake, placed between the accumulator and the TCU writeback.

---
 rtl/vx_tcu_drl_norm_pack_if.sv | 41 ++++
 rtl/vx_tcu_drl_norm_pack.sv | 191 +++++++++++++++++++
 tb/tb_vx_tcu_drl_norm_pack.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_tcu_drl_norm_pack_if.sv
// ---------------------------------------------------------------------------
// vx_tcu_drl_norm_pack_if
// Handshake/data bundle for the DRL normalize-and-pack back end.
//   Input side : valid_in / ready_in, acc_in, sticky_in, exp_in,
//                is_nan_in, is_inf_in, inf_sign_in, tag_in
//   Output side: valid_out / ready_out, result (FP32), tag_out
// Modports:
//   slave  - the normalize/pack block (consumes input beats, drives results)
//   master - the environment around it (accumulator + writeback side)
// ---------------------------------------------------------------------------
interface vx_tcu_drl_norm_pack_if #(
    parameter int WA    = 28,
    parameter int EXP_W = 10,
    parameter int TAG_W = 8
);
    logic                    valid_in;
    logic                    ready_in;
    logic signed [WA-1:0]    acc_in;
    logic                    sticky_in;
    logic [EXP_W-1:0]        exp_in;
    logic                    is_nan_in;
    logic                    is_inf_in;
    logic                    inf_sign_in;
    logic [TAG_W-1:0]        tag_in;
    logic                    valid_out;
    logic                    ready_out;
    logic [31:0]             result;
    logic [TAG_W-1:0]        tag_out;

    modport slave (
        input  valid_in, acc_in, sticky_in, exp_in, is_nan_in, is_inf_in,
               inf_sign_in, tag_in, ready_out,
        output ready_in, valid_out, result, tag_out
    );

    modport master (
        output valid_in, acc_in, sticky_in, exp_in, is_nan_in, is_inf_in,
               inf_sign_in, tag_in, ready_out,
        input  ready_in, valid_out, result, tag_out
    );
endinterface

// File: rtl/vx_tcu_drl_norm_pack.sv
// ---------------------------------------------------------------------------
// vx_tcu_drl_norm_pack
// Back end of the TCU DRL dot-product datapath: takes the signed fixed-point
// window accumulator plus its biased window exponent, normalizes the
// magnitude, rounds to nearest-even and packs an IEEE FP32 result.
// Value carried in: acc_in * 2^(exp_in - 127 - (WA-2)).
// Three-stage elastic pipeline (valid/ready), one beat per cycle.
// Ports:
//   clk      - clock
//   reset_n  - asynchronous active-low reset (clears valids and the output)
//   bus      - slave side of vx_tcu_drl_norm_pack_if (input beat, result beat)
// ---------------------------------------------------------------------------
module vx_tcu_drl_norm_pack #(
    parameter int WA    = 28,
    parameter int EXP_W = 10,
    parameter int TAG_W = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    vx_tcu_drl_norm_pack_if.slave  bus
);
    localparam int LZW   = $clog2(WA);
    localparam int EW2   = EXP_W + 2;
    localparam int MAN_W = 23;

    localparam logic signed [EW2-1:0] E_MAX  = EW2'(255);
    localparam logic signed [EW2-1:0] E_ZERO = '0;

    // Bit index of the most significant one (0 when m is zero).
    function automatic logic [LZW-1:0] lead_pos(input logic [WA-1:0] m);
        logic [LZW-1:0] p;
        p = '0;
        for (int i = 0; i < WA; i++) begin
            if (m[i]) p = LZW'(i);
        end
        return p;
    endfunction

    // Round-to-nearest-even; returns {carry_out, mantissa}.
    function automatic logic [MAN_W:0] round_rne(input logic [MAN_W-1:0] man,
                                                 input logic guard,
                                                 input logic stk);
        logic inc;
        inc = guard && (stk || man[0]);
        return {1'b0, man} + {{MAN_W{1'b0}}, inc};
    endfunction

    function automatic logic [31:0] pack_fp32(input logic nan,
                                              input logic inf,
                                              input logic inf_sign,
                                              input logic zero,
                                              input logic sign,
                                              input logic signed [EW2-1:0] e,
                                              input logic [MAN_W-1:0] man);
        if (nan)              return 32'h7FC0_0000;
        else if (inf)         return {inf_sign, 8'hFF, 23'b0};
        else if (zero)        return 32'h0000_0000;
        else if (e >= E_MAX)  return {sign, 8'hFF, 23'b0};
        else if (e <= E_ZERO) return {sign, 31'b0};
        else                  return {sign, e[7:0], man};
    endfunction

    // ---------------- handshake ----------------
    logic vld_p0, vld_p1, vld_p2;
    logic adv_p0, adv_p1, adv_p2;
    logic fire_in;

    assign adv_p2  = !vld_p2 || bus.ready_out;
    assign adv_p1  = !vld_p1 || adv_p2;
    assign adv_p0  = !vld_p0 || adv_p1;
    assign fire_in = bus.valid_in && adv_p0;

    assign bus.ready_in  = adv_p0;
    assign bus.valid_out = vld_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            if (adv_p0) vld_p0 <= bus.valid_in;
            if (adv_p1) vld_p1 <= vld_p0;
            if (adv_p2) vld_p2 <= vld_p1;
        end
    end

    // ---------------- S0: sign / magnitude / lead position ----------------
    logic [WA-1:0]  mag_s0;
    logic           sign_s0;
    logic [LZW-1:0] lead_s0;
    logic           zero_s0;

    always_comb begin
        sign_s0 = bus.acc_in[WA-1];
        // Negating the most negative value wraps to exactly bit WA-1.
        mag_s0  = sign_s0 ? WA'(-bus.acc_in) : WA'(bus.acc_in);
        lead_s0 = lead_pos(mag_s0);
        zero_s0 = (mag_s0 == '0) || bus.exp_in[EXP_W-1];
    end

    logic             sign_p0, zero_p0, sticky_p0, nan_p0, inf_p0, isg_p0;
    logic [WA-1:0]    mag_p0;
    logic [LZW-1:0]   lead_p0;
    logic [EXP_W-1:0] exp_p0;
    logic [TAG_W-1:0] tag_p0;

    always_ff @(posedge clk) begin
        if (fire_in) begin
            sign_p0   <= sign_s0;
            mag_p0    <= mag_s0;
            lead_p0   <= lead_s0;
            zero_p0   <= zero_s0;
            exp_p0    <= bus.exp_in;
            sticky_p0 <= bus.sticky_in;
            nan_p0    <= bus.is_nan_in;
            inf_p0    <= bus.is_inf_in;
            isg_p0    <= bus.inf_sign_in;
            tag_p0    <= bus.tag_in;
        end
    end

    // ---------------- S1: normalize, split mantissa/guard/sticky ----------------
    // The leading one (always at WA-1 after the shift) is implicit and dropped.
    logic [WA-2:0]           norm_s1;
    logic [LZW-1:0]          sh_s1;
    logic [MAN_W-1:0]        man_s1;
    logic                    guard_s1, stk_s1;
    logic signed [EW2-1:0]   e_s1;

    always_comb begin
        sh_s1    = LZW'(WA-1) - lead_p0;
        norm_s1  = (WA-1)'(mag_p0 << sh_s1);
        man_s1   = norm_s1[WA-2 -: MAN_W];
        guard_s1 = norm_s1[WA-MAN_W-2];
        stk_s1   = (|norm_s1[WA-MAN_W-3:0]) | sticky_p0;
        e_s1     = $signed({2'b00, exp_p0})
                 + $signed({{(EW2-LZW){1'b0}}, lead_p0})
                 - $signed(EW2'(WA-2));
    end

    logic                  sign_p1, zero_p1, guard_p1, stk_p1, nan_p1, inf_p1, isg_p1;
    logic [MAN_W-1:0]      man_p1;
    logic signed [EW2-1:0] e_p1;
    logic [TAG_W-1:0]      tag_p1;

    always_ff @(posedge clk) begin
        if (adv_p1 && vld_p0) begin
            sign_p1  <= sign_p0;
            zero_p1  <= zero_p0;
            man_p1   <= man_s1;
            guard_p1 <= guard_s1;
            stk_p1   <= stk_s1;
            e_p1     <= e_s1;
            nan_p1   <= nan_p0;
            inf_p1   <= inf_p0;
            isg_p1   <= isg_p0;
            tag_p1   <= tag_p0;
        end
    end

    // ---------------- S2: round and pack ----------------
    logic [MAN_W:0]        rnd_s2;
    logic signed [EW2-1:0] e_s2;
    logic [31:0]           res_s2;

    always_comb begin
        rnd_s2 = round_rne(man_p1, guard_p1, stk_p1);
        // A carry out leaves the mantissa field at zero and bumps the exponent.
        e_s2   = e_p1 + $signed({{(EW2-1){1'b0}}, rnd_s2[MAN_W]});
        res_s2 = pack_fp32(nan_p1, inf_p1, isg_p1, zero_p1, sign_p1, e_s2,
                           rnd_s2[MAN_W-1:0]);
    end

    logic [31:0]      result_p2;
    logic [TAG_W-1:0] tag_p2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_p2 <= '0;
            tag_p2    <= '0;
        end else if (adv_p2 && vld_p1) begin
            result_p2 <= res_s2;
            tag_p2    <= tag_p1;
        end
    end

    assign bus.result  = result_p2;
    assign bus.tag_out = tag_p2;

endmodule

// File: tb/tb_vx_tcu_drl_norm_pack.sv
module tb_vx_tcu_drl_norm_pack;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    vx_tcu_drl_norm_pack_if #(.WA(28), .EXP_W(10), .TAG_W(8)) bus ();

    vx_tcu_drl_norm_pack #(.WA(28), .EXP_W(10), .TAG_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [27:0] acc;
        bit          stk;
        logic [9:0]  ex;
        bit          nan;
        bit          inf;
        bit          isg;
        logic [31:0] res;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int n_out = 0;
    logic [39:0] exp_q[$];
    logic [31:0] cur_exp;
    bit last_fi, last_fo, last_ri, last_vo, last_ro;
    logic [31:0] last_res;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Reference: round the exact value m*2^(ex-153) to 24 significant bits.
    function automatic logic [31:0] model(input logic [27:0] acc, input bit stk,
                                          input logic [9:0] ex, input bit nan,
                                          input bit inf, input bit isg);
        logic signed [27:0] as;
        longint a, m, q, rem, half;
        int k, e, sh;
        bit sign, up;
        logic [31:0] r;
        if (nan) return 32'h7FC0_0000;
        if (inf) return {isg, 8'hFF, 23'b0};
        as = acc;
        a = as;
        sign = (a < 0);
        m = sign ? -a : a;
        if (m == 0 || ex[9]) return 32'h0;
        k = 0;
        while ((m >> (k + 1)) != 0) k++;
        e = int'(ex) + k - 26;
        if (k > 23) begin
            sh = k - 23;
            q = m >> sh;
            rem = m - (q << sh);
            half = longint'(1) << (sh - 1);
            // sticky_in is a nonzero amount below one accumulator LSB
            up = (rem > half) || (rem == half && (stk || q[0]));
            if (up) q = q + 1;
        end else begin
            q = m << (23 - k);
        end
        if (q == (longint'(1) << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {sign, 8'hFF, 23'b0};
        if (e <= 0) return {sign, 31'b0};
        r = {sign, 8'(e), q[22:0]};
        return r;
    endfunction

    // Called at a falling edge with inputs already driven; samples before the
    // next rising edge, updates the scoreboard, returns at the next falling edge.
    task automatic tick();
        logic [39:0] ent;
        #1;
        last_fi  = bus.valid_in && bus.ready_in;
        last_fo  = bus.valid_out && bus.ready_out;
        last_ri  = bus.ready_in;
        last_vo  = bus.valid_out;
        last_ro  = bus.ready_out;
        last_res = bus.result;
        if (last_fi) exp_q.push_back({cur_exp, bus.tag_in});
        if (last_fo) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got result %h tag %h, required no beat", bus.result, bus.tag_out);
            end else begin
                ent = exp_q.pop_front();
                check("result", bus.result, ent[39:8]);
                check("tag", {24'b0, bus.tag_out}, {24'b0, ent[7:0]});
                n_out++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [27:0] acc, input bit stk, input logic [9:0] ex,
                         input bit nan, input bit inf, input bit isg, input logic [7:0] tag);
        bus.acc_in = acc; bus.sticky_in = stk; bus.exp_in = ex;
        bus.is_nan_in = nan; bus.is_inf_in = inf; bus.inf_sign_in = isg; bus.tag_in = tag;
    endtask

    vec_t vecs[16];

    initial begin
        int lat, sent, seen, c;
        bit hold, stall_prev;
        logic [31:0] held_res;
        logic [27:0] bp_acc[6];
        logic [27:0] racc;
        logic [9:0]  rex;
        bit rstk, rnan, rinf, risg;

        vecs[0]  = '{28'h400_0000, 0, 10'd127, 0, 0, 0, 32'h3F80_0000};
        vecs[1]  = '{28'hC00_0000, 0, 10'd127, 0, 0, 0, 32'hBF80_0000};
        vecs[2]  = '{28'h800_0000, 0, 10'd127, 0, 0, 0, 32'hC000_0000};
        vecs[3]  = '{28'h400_0004, 0, 10'd127, 0, 0, 0, 32'h3F80_0000};
        vecs[4]  = '{28'h400_000C, 0, 10'd127, 0, 0, 0, 32'h3F80_0002};
        vecs[5]  = '{28'h400_0004, 1, 10'd127, 0, 0, 0, 32'h3F80_0001};
        vecs[6]  = '{28'h7FF_FFFF, 0, 10'd254, 0, 0, 0, 32'h7F80_0000};
        vecs[7]  = '{28'h000_0001, 0, 10'd10,  0, 0, 0, 32'h0000_0000};
        vecs[8]  = '{28'h123_4567, 0, 10'h200, 0, 0, 0, 32'h0000_0000};
        vecs[9]  = '{28'h400_0000, 0, 10'd127, 1, 0, 0, 32'h7FC0_0000};
        vecs[10] = '{28'h400_0000, 0, 10'd127, 0, 1, 1, 32'hFF80_0000};
        vecs[11] = '{28'hC00_0000, 0, 10'h200, 0, 0, 0, 32'h0000_0000};
        vecs[12] = '{28'hFFF_FFFF, 0, 10'd10,  0, 0, 0, 32'h8000_0000};
        vecs[13] = '{28'h400_0000, 0, 10'd281, 0, 0, 0, 32'h7F80_0000};
        vecs[14] = '{28'h000_0000, 0, 10'd127, 0, 0, 0, 32'h0000_0000};
        vecs[15] = '{28'h400_0000, 0, 10'd128, 1, 1, 1, 32'h7FC0_0000};

        bus.valid_in = 0; bus.ready_out = 1;
        drive('0, 0, '0, 0, 0, 0, '0);
        cur_exp = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid_out", {31'b0, bus.valid_out}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_tag", {24'b0, bus.tag_out}, 32'd0);
        @(negedge clk);
        reset_n = 1;
        #1;
        check("rst_ready_in", {31'b0, bus.ready_in}, 32'd1);
        @(negedge clk);

        // Directed vectors, one isolated beat each.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].acc, vecs[i].stk, vecs[i].ex, vecs[i].nan, vecs[i].inf,
                  vecs[i].isg, 8'(8'hA0 + i));
            cur_exp = vecs[i].res;
            bus.valid_in = 1;
            tick();
            bus.valid_in = 0;
            lat = 0;
            for (int k = 1; k <= 10; k++) begin
                tick();
                if (last_fo) begin lat = k; break; end
            end
            if (lat == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL vec%0d_timeout: got no output, required one", i);
            end
            // Presented in cycle 0, valid after the third rising edge.
            if (i == 0) check("latency", lat, 32'd3);
        end

        // Backpressure: 6 beats, ready_out low for 4 cycles mid-stream.
        for (int i = 0; i < 6; i++) bp_acc[i] = 28'($urandom);
        sent = 0; seen = n_out; stall_prev = 0; held_res = '0;
        c = 0;
        while (!(sent == 6 && exp_q.size() == 0) && c < 40) begin
            bus.valid_in = (sent < 6);
            if (sent < 6) begin
                drive(bp_acc[sent], 0, 10'd127, 0, 0, 0, 8'(8'h50 + sent));
                cur_exp = model(bp_acc[sent], 0, 10'd127, 0, 0, 0);
            end
            bus.ready_out = !(c >= 2 && c <= 5);
            tick();
            if (last_fi) sent++;
            if (c == 3) check("bp_ready_in_low", {31'b0, last_ri}, 32'd0);
            if (stall_prev) check("bp_hold", last_res, held_res);
            stall_prev = last_vo && !last_ro;
            held_res = last_res;
            c++;
        end
        bus.valid_in = 0; bus.ready_out = 1;
        check("bp_count", n_out - seen, 32'd6);

        // Randomized traffic against the reference model.
        hold = 0;
        racc = '0; rex = '0; rstk = 0; rnan = 0; rinf = 0; risg = 0;
        for (int n = 0; n < 400; n++) begin
            if (!hold) begin
                racc = 28'($urandom >> $urandom_range(4, 31));
                rex  = 10'($urandom_range(0, 400));
                if ($urandom_range(0, 15) == 0) rex[9] = 1'b1;
                rstk = ($urandom_range(0, 3) == 0);
                rnan = ($urandom_range(0, 19) == 0);
                rinf = ($urandom_range(0, 19) == 0);
                risg = 1'($urandom);
                bus.valid_in = ($urandom_range(0, 3) != 0);
                drive(racc, rstk, rex, rnan, rinf, risg, 8'($urandom));
                cur_exp = model(racc, rstk, rex, rnan, rinf, risg);
            end
            bus.ready_out = ($urandom_range(0, 2) != 0);
            tick();
            hold = bus.valid_in && !last_fi;
        end
        bus.valid_in = 0; bus.ready_out = 1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("drain_empty", exp_q.size(), 32'd0);

        // Reset with three beats in flight.
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            drive(28'h400_0000, 0, 10'd127, 0, 0, 0, 8'(8'h70 + i));
            cur_exp = 32'h3F80_0000;
            bus.valid_in = 1;
            tick();
        end
        bus.valid_in = 0;
        reset_n = 0;
        #1;
        check("rst_mid_valid_out", {31'b0, bus.valid_out}, 32'd0);
        check("rst_mid_result", bus.result, 32'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (last_vo) seen++;
        end
        check("no_stale", seen, 32'd0);
        check("post_rst_ready_in", {31'b0, last_ri}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
